stream_xbar_sched: RTL
======================

Name: stream_xbar_sched

Overview:
Registered, packet-locking scheduler for the S-to-M streaming crossbar. Each master port has its own round-robin arbiter. An arbiter locks to one source from the first beat until that source's last beat is accepted. s_ready_o is a true handshake: m_ready_i of the destination, gated by the grant. Supplies the per-master select (grant_o, m_id_o) that the crossbar datapath uses for data muxing.

Parameters:
S_DATA_COUNT, 3, number of source (slave-side) ports, >=1
M_DATA_COUNT, 3, number of master-side ports, >=1
T_ID___WIDTH, (S_DATA_COUNT>1 ? $clog2(S_DATA_COUNT) : 1), width of m_id_o per master
T_DEST_WIDTH, (M_DATA_COUNT>1 ? $clog2(M_DATA_COUNT) : 1), width of s_dest_i per source
LOCK_TIMEOUT, 256, idle-beat limit, used only with the optional feature

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
s_dest_i  in  T_DEST_WIDTH*S_DATA_COUNT  destination index per source
s_valid_i  in  S_DATA_COUNT  source beat valid
s_last_i  in  S_DATA_COUNT  source beat is packet end
m_ready_i  in  M_DATA_COUNT  master accepts beat
s_ready_o  out  S_DATA_COUNT  source beat accepted when high with s_valid_i
m_valid_o  out  M_DATA_COUNT  beat valid toward master
m_last_o  out  M_DATA_COUNT  last flag toward master
m_id_o  out  M_DATA_COUNT*T_ID___WIDTH  source index routed to master m, field [m*T_ID___WIDTH +: T_ID___WIDTH]
grant_o  out  S_DATA_COUNT*M_DATA_COUNT  one-hot per master, bit [m*S_DATA_COUNT+s]

Behaviour:
- Per-master state: IDLE / LOCKED; lock_id register; rr_ptr register holding the last granted source.
- Reset, asynchronous: all masters go to IDLE, lock_id=0, rr_ptr=S_DATA_COUNT-1, so source 0 has first priority.
- Outputs are combinational from state plus inputs. With rst high, every output is 0.
- Request to master m from source s: s_valid_i[s], s_dest_i[s]==m, and s not LOCKED at any master.
- IDLE: if any request exists, pick the first requesting source scanning upward from rr_ptr+1, with wrap. The master goes LOCKED on the next edge with lock_id = that source. Arbitration latency is 1 cycle.
- In IDLE: no grant, m_valid_o[m]=0, m_last_o[m]=0, m_id_o field=0.
- LOCKED (source s=lock_id):
  - grant_o[m*S+s]=1
  - m_valid_o[m]=s_valid_i[s]
  - m_last_o[m]=s_valid_i[s]&s_last_i[s]
  - s_ready_o[s]=m_ready_i[m]
  - m_id_o field=s
- LOCKED transfer occurs when s_valid_i[s] and m_ready_i[m] are both high.
- Transfer with s_last_i[s]: go to IDLE next edge and set rr_ptr=s. A new packet can be granted from the following cycle (1 idle cycle between packets).
- While LOCKED, s_dest_i[s] is ignored. The source stays bound to m until last, even if dest changes mid-packet.
- Single-beat packet (last on first beat): LOCK, transfer, then IDLE. Total occupancy is 2 cycles.
- s_dest_i >= M_DATA_COUNT: the source is never requested. It receives s_ready_o=1 while s_valid_i is high, so the beat is dropped and the source cannot hang.
- A source that is not locked, with a valid in-range dest: s_ready_o=0.
- M_DATA_COUNT=1 or S_DATA_COUNT=1: the 1-bit widths above apply, with no zero-width slices.
- Reset mid-packet: the lock is lost immediately and the next beat is re-arbitrated as a new packet.

Optional Feature:
Macro XBAR_SCHED_LOCK_TIMEOUT_EN.
- Defined: each master has a counter of consecutive LOCKED cycles with s_valid_i[lock_id]=0, cleared by any valid beat.
  - When the count reaches LOCK_TIMEOUT, the master returns to IDLE, rr_ptr=lock_id, and a 1-cycle pulse appears on extra output port timeout_o[M_DATA_COUNT].
- Undefined: no counter and no timeout_o port. A lock is held indefinitely until last.

Test Plan:
- S=M=3, src0 dest=1 sends a 4-beat packet, m_ready=1 → grant_o bit 3 from cycle 1, m_id_o[m1]=0, 4 transfers, IDLE after last.
- src0 and src2 both dest=0, continuous 2-beat packets → grants alternate 0,2,0,2, with 1 idle cycle between packets.
- src1 locked to m2; src1 dest changes to 0 mid-packet → beats stay on m2 until last, and m0 sees no request from src1.
- m_ready_i[1] toggling 1,0,1,0 during a locked packet → s_ready_o of the locked source mirrors it, and no beat is lost or duplicated.
- M=3, T_DEST_WIDTH=2, src0 dest=3 valid → s_ready_o[0]=1, all m_valid_o=0. S=1,M=1 build elaborates and passes the first scenario.
- With XBAR_SCHED_LOCK_TIMEOUT_EN and LOCK_TIMEOUT=4, a locked source stops valid → timeout_o pulses after 4 cycles, the master goes IDLE, and a waiting source is granted next.

Source files
------------

// File: rtl/stream_xbar_sched_if.sv
// stream_xbar_sched_if: source/master handshake and select bundle of the crossbar scheduler; timeout_o exists only with XBAR_SCHED_LOCK_TIMEOUT_EN
interface stream_xbar_sched_if #(
  parameter int S_DATA_COUNT = 3,
  parameter int M_DATA_COUNT = 3,
  parameter int T_ID___WIDTH = (S_DATA_COUNT > 1 ? $clog2(S_DATA_COUNT) : 1),
  parameter int T_DEST_WIDTH = (M_DATA_COUNT > 1 ? $clog2(M_DATA_COUNT) : 1)
);
  logic [T_DEST_WIDTH*S_DATA_COUNT-1:0] s_dest_i;
  logic [S_DATA_COUNT-1:0] s_valid_i;
  logic [S_DATA_COUNT-1:0] s_last_i;
  logic [M_DATA_COUNT-1:0] m_ready_i;
  logic [S_DATA_COUNT-1:0] s_ready_o;
  logic [M_DATA_COUNT-1:0] m_valid_o;
  logic [M_DATA_COUNT-1:0] m_last_o;
  logic [M_DATA_COUNT*T_ID___WIDTH-1:0] m_id_o;
  logic [S_DATA_COUNT*M_DATA_COUNT-1:0] grant_o;
`ifdef XBAR_SCHED_LOCK_TIMEOUT_EN
  logic [M_DATA_COUNT-1:0] timeout_o;
  modport slave (input s_dest_i, s_valid_i, s_last_i, m_ready_i,
                 output s_ready_o, m_valid_o, m_last_o, m_id_o, grant_o, timeout_o);
  modport master (output s_dest_i, s_valid_i, s_last_i, m_ready_i,
                  input s_ready_o, m_valid_o, m_last_o, m_id_o, grant_o, timeout_o);
`else
  modport slave (input s_dest_i, s_valid_i, s_last_i, m_ready_i,
                 output s_ready_o, m_valid_o, m_last_o, m_id_o, grant_o);
  modport master (output s_dest_i, s_valid_i, s_last_i, m_ready_i,
                  input s_ready_o, m_valid_o, m_last_o, m_id_o, grant_o);
`endif
endinterface

// File: rtl/stream_xbar_sched.sv
// stream_xbar_sched: per-master round-robin packet-locking scheduler for an S-to-M stream crossbar; define XBAR_SCHED_LOCK_TIMEOUT_EN to release idle locks after LOCK_TIMEOUT cycles
module stream_xbar_sched #(
  parameter int S_DATA_COUNT = 3,
  parameter int M_DATA_COUNT = 3,
  parameter int T_ID___WIDTH = (S_DATA_COUNT > 1 ? $clog2(S_DATA_COUNT) : 1),
  parameter int T_DEST_WIDTH = (M_DATA_COUNT > 1 ? $clog2(M_DATA_COUNT) : 1)
`ifdef XBAR_SCHED_LOCK_TIMEOUT_EN
  , parameter int LOCK_TIMEOUT = 256
`endif
) (
  input logic clk,
  input logic rst,
  stream_xbar_sched_if.slave bus
);
  localparam int S = S_DATA_COUNT;
  localparam int M = M_DATA_COUNT;
  localparam int IW = T_ID___WIDTH;
  localparam int DW = T_DEST_WIDTH;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;
  logic [0:0] state [M];
  logic [IW-1:0] lock_id [M];
  logic [IW-1:0] rr_ptr [M];
  logic [IW-1:0] pick [M];
  logic [M-1:0] has_req;
  logic [M-1:0] tmo;
  logic [S-1:0] bound;
  logic [S-1:0] s_ready;
  logic [M-1:0] m_valid;
  logic [M-1:0] m_last;
  logic [M*IW-1:0] m_id;
  logic [S*M-1:0] grant;
  int idx;
  // sources already locked by some master never request anywhere else
  always_comb begin
    bound = '0;
    for (int m = 0; m < M; m++)
      for (int s = 0; s < S; s++)
        if (state[m] == LOCKED && lock_id[m] == IW'(s)) bound[s] = 1'b1;
  end
  // per-master round-robin pick: first requester after rr_ptr, wrapping
  always_comb begin
    has_req = '0;
    idx = 0;
    for (int m = 0; m < M; m++) begin
      pick[m] = '0;
      for (int i = 1; i <= S; i++) begin
        idx = int'(rr_ptr[m]) + i;
        idx = idx >= S ? idx - S : idx;
        if (!has_req[m] && bus.s_valid_i[idx] && !bound[idx] && int'(bus.s_dest_i[idx*DW +: DW]) == m) begin
          has_req[m] = 1'b1;
          pick[m] = IW'(idx);
        end
      end
    end
  end
  // a locked master routes its source's handshake; unbound beats to a missing master are drained
  always_comb begin
    s_ready = '0;
    m_valid = '0;
    m_last = '0;
    m_id = '0;
    grant = '0;
    for (int m = 0; m < M; m++)
      for (int s = 0; s < S; s++)
        if (state[m] == LOCKED && lock_id[m] == IW'(s)) begin
          grant[m*S+s] = 1'b1;
          m_valid[m] = bus.s_valid_i[s];
          m_last[m] = bus.s_valid_i[s] & bus.s_last_i[s];
          s_ready[s] = bus.m_ready_i[m];
          m_id[m*IW +: IW] = lock_id[m];
        end
    for (int s = 0; s < S; s++)
      if (!bound[s] && bus.s_valid_i[s] && int'(bus.s_dest_i[s*DW +: DW]) >= M) s_ready[s] = 1'b1;
  end
  assign bus.s_ready_o = rst ? '0 : s_ready;
  assign bus.m_valid_o = rst ? '0 : m_valid;
  assign bus.m_last_o = rst ? '0 : m_last;
  assign bus.m_id_o = rst ? '0 : m_id;
  assign bus.grant_o = rst ? '0 : grant;
`ifdef XBAR_SCHED_LOCK_TIMEOUT_EN
  localparam int CW = $clog2(LOCK_TIMEOUT + 1);
  logic [CW-1:0] idle_cnt [M];
  // the lock expires on the idle cycle that brings the count to LOCK_TIMEOUT
  always_comb begin
    tmo = '0;
    for (int m = 0; m < M; m++)
      tmo[m] = state[m] == LOCKED && !m_valid[m] && idle_cnt[m] == CW'(LOCK_TIMEOUT - 1);
  end
  // consecutive locked cycles without a valid beat, cleared by any beat or release
  always_ff @(posedge clk or posedge rst)
    if (rst)
      for (int m = 0; m < M; m++) idle_cnt[m] <= '0;
    else
      for (int m = 0; m < M; m++)
        idle_cnt[m] <= (state[m] == LOCKED && !m_valid[m] && !tmo[m]) ? idle_cnt[m] + CW'(1) : '0;
  assign bus.timeout_o = rst ? '0 : tmo;
`else
  assign tmo = '0;
`endif
  // idle masters lock onto their pick; locked masters release on an accepted last beat or a timeout
  always_ff @(posedge clk or posedge rst)
    if (rst)
      for (int m = 0; m < M; m++) begin
        state[m] <= IDLE;
        lock_id[m] <= '0;
        rr_ptr[m] <= IW'(S - 1);
      end
    else
      for (int m = 0; m < M; m++)
        if (state[m] == IDLE) begin
          if (has_req[m]) begin
            state[m] <= LOCKED;
            lock_id[m] <= pick[m];
          end
        end else if ((m_last[m] && bus.m_ready_i[m]) || tmo[m]) begin
          state[m] <= IDLE;
          rr_ptr[m] <= lock_id[m];
        end
endmodule
